// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and
// load-use hazard detection, feeding the 16-bit ALU.
module id_ex_stage #(
  parameter int WIDTH = 16,
  parameter int RA    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [RA-1:0]    id_rs,
  input  logic [RA-1:0]    id_rt,
  input  logic [RA-1:0]    id_rd,
  input  logic [WIDTH-1:0] id_rs_data,
  input  logic [WIDTH-1:0] id_rt_data,
  input  logic [WIDTH-1:0] id_imm,
  input  logic             id_uses_rt,
  input  logic             id_alu_src,
  input  logic [2:0]       id_alu_control,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_mem_to_reg,
  input  logic             id_branch,
  input  logic             stall,
  input  logic             flush,
  input  logic             exm_reg_write,
  input  logic [RA-1:0]    exm_rd,
  input  logic [WIDTH-1:0] exm_result,
  input  logic             wb_reg_write,
  input  logic [RA-1:0]    wb_rd,
  input  logic [WIDTH-1:0] wb_result,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_control,
  output logic [WIDTH-1:0] ex_store_data,
  output logic [RA-1:0]    ex_rd,
  output logic             ex_valid,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_mem_to_reg,
  output logic             ex_branch,
  output logic             load_use_stall
);

  typedef struct packed {
    logic             valid;
    logic [RA-1:0]    rs;
    logic [RA-1:0]    rt;
    logic [RA-1:0]    rd;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic [WIDTH-1:0] imm;
    logic             alu_src;
    logic [2:0]       alu_control;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             branch;
  } stage_t;

  localparam stage_t BUBBLE = '0;
  localparam logic [RA-1:0] R0 = {RA{1'b0}};

  stage_t           stage_q;
  stage_t           stage_d;
  stage_t           id_pkt;
  logic             load_use_d;
  logic [WIDTH-1:0] fwd_rs_d;
  logic [WIDTH-1:0] fwd_rt_d;
  logic [WIDTH-1:0] alu_b_d;

  // EX/MEM is the younger producer, so it is checked first; r0 never forwards.
  function automatic logic [WIDTH-1:0] fwd_select(
    input logic [RA-1:0]    src,
    input logic [WIDTH-1:0] reg_val,
    input logic             em_we,
    input logic [RA-1:0]    em_rd,
    input logic [WIDTH-1:0] em_val,
    input logic             wb_we,
    input logic [RA-1:0]    wbk_rd,
    input logic [WIDTH-1:0] wb_val
  );
    logic [WIDTH-1:0] sel;
    if (src == R0) begin
      sel = reg_val;
    end else if (em_we && (em_rd == src)) begin
      sel = em_val;
    end else if (wb_we && (wbk_rd == src)) begin
      sel = wb_val;
    end else begin
      sel = reg_val;
    end
    return sel;
  endfunction

  // Pack the decode slot into stage layout.
  always_comb begin
    id_pkt             = BUBBLE;
    id_pkt.valid       = id_valid;
    id_pkt.rs          = id_rs;
    id_pkt.rt          = id_rt;
    id_pkt.rd          = id_rd;
    id_pkt.rs_data     = id_rs_data;
    id_pkt.rt_data     = id_rt_data;
    id_pkt.imm         = id_imm;
    id_pkt.alu_src     = id_alu_src;
    id_pkt.alu_control = id_alu_control;
    id_pkt.reg_write   = id_reg_write;
    id_pkt.mem_read    = id_mem_read;
    id_pkt.mem_write   = id_mem_write;
    id_pkt.mem_to_reg  = id_mem_to_reg;
    id_pkt.branch      = id_branch;
  end

  // Load in EX whose destination is read by the instruction in decode.
  always_comb begin
    load_use_d = 1'b0;
    if (stage_q.valid && stage_q.mem_read && (stage_q.rd != R0) && id_valid) begin
      if (stage_q.rd == id_rs) begin
        load_use_d = 1'b1;
      end else if (id_uses_rt && (stage_q.rd == id_rt)) begin
        load_use_d = 1'b1;
      end else begin
        load_use_d = 1'b0;
      end
    end else begin
      load_use_d = 1'b0;
    end
  end

  // Next-state priority: flush, then stall hold, then load-use bubble.
  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = BUBBLE;
    end else if (stall) begin
      stage_d = stage_q;
    end else if (load_use_d) begin
      stage_d = BUBBLE;
    end else begin
      stage_d = id_pkt;
    end
  end

  // Stage register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q <= BUBBLE;
    end else begin
      stage_q <= stage_d;
    end
  end

  // Operand forwarding and ALU b selection.
  always_comb begin
    fwd_rs_d = fwd_select(stage_q.rs, stage_q.rs_data, exm_reg_write, exm_rd,
                          exm_result, wb_reg_write, wb_rd, wb_result);
    fwd_rt_d = fwd_select(stage_q.rt, stage_q.rt_data, exm_reg_write, exm_rd,
                          exm_result, wb_reg_write, wb_rd, wb_result);
    if (stage_q.alu_src) begin
      alu_b_d = stage_q.imm;
    end else begin
      alu_b_d = fwd_rt_d;
    end
  end

  assign alu_a          = fwd_rs_d;
  assign alu_b          = alu_b_d;
  assign ex_store_data  = fwd_rt_d;
  assign alu_control    = stage_q.alu_control;
  assign ex_rd          = stage_q.rd;
  assign ex_valid       = stage_q.valid;
  assign ex_reg_write   = stage_q.reg_write;
  assign ex_mem_read    = stage_q.mem_read;
  assign ex_mem_write   = stage_q.mem_write;
  assign ex_mem_to_reg  = stage_q.mem_to_reg;
  assign ex_branch      = stage_q.branch;
  assign load_use_stall = load_use_d;

  id_ex_stage_checker #(.RA(RA)) u_checker (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .ex_valid       (ex_valid),
    .ex_mem_read    (ex_mem_read),
    .ex_rd          (ex_rd),
    .alu_control    (alu_control),
    .load_use_stall (load_use_stall)
  );

endmodule

// Protocol properties of the ID/EX stage.
module id_ex_stage_checker #(
  parameter int RA = 3
) (
  input logic          clk,
  input logic          reset,
  input logic          stall,
  input logic          flush,
  input logic          ex_valid,
  input logic          ex_mem_read,
  input logic [RA-1:0] ex_rd,
  input logic [2:0]    alu_control,
  input logic          load_use_stall
);

  a_lus_needs_load: assert property (@(posedge clk) disable iff (reset)
    load_use_stall |-> (ex_valid && ex_mem_read && (ex_rd != {RA{1'b0}})));

  a_flush_bubble: assert property (@(posedge clk) disable iff (reset)
    flush |=> !ex_valid);

  a_stall_holds: assert property (@(posedge clk) disable iff (reset)
    (stall && !flush) |=> ($stable(ex_valid) && $stable(ex_rd) && $stable(alu_control)));

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed vector table plus randomized run against a reference model.
module tb_id_ex_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        id_valid, id_uses_rt, id_alu_src;
  logic [2:0]  id_rs, id_rt, id_rd, id_alu_control;
  logic [15:0] id_rs_data, id_rt_data, id_imm;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch;
  logic        stall, flush;
  logic        exm_reg_write, wb_reg_write;
  logic [2:0]  exm_rd, wb_rd;
  logic [15:0] exm_result, wb_result;
  logic [15:0] alu_a, alu_b, ex_store_data;
  logic [2:0]  alu_control, ex_rd;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;
  logic        load_use_stall;

  id_ex_stage #(.WIDTH(16), .RA(3)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_uses_rt(id_uses_rt), .id_alu_src(id_alu_src), .id_alu_control(id_alu_control),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
    .stall(stall), .flush(flush),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
    .load_use_stall(load_use_stall)
  );

  // ctl5 = {reg_write, mem_read, mem_write, mem_to_reg, branch}
  typedef struct packed {
    logic        valid;
    logic [2:0]  rs, rt, rd;
    logic [15:0] rs_data, rt_data, imm;
    logic        uses_rt, alu_src;
    logic [2:0]  ctl;
    logic [4:0]  ctl5;
  } id_t;

  typedef struct packed {
    logic        exm_we;
    logic [2:0]  exm_rd;
    logic [15:0] exm_res;
    logic        wb_we;
    logic [2:0]  wb_rd;
    logic [15:0] wb_res;
  } fwd_t;

  typedef struct packed {
    logic [15:0] a, b;
    logic [2:0]  ctl;
    logic [15:0] sd;
    logic [2:0]  rd;
    logic [5:0]  c6;
    logic        lus;
  } exp_t;

  typedef struct {
    logic rst, stl, fls;
    id_t  id;
    fwd_t fw;
    exp_t e;
  } row_t;

  int   vectors = 0;
  int   miscompares = 0;
  row_t rows[$];

  function automatic id_t ins(logic [2:0] rs, logic [2:0] rt, logic [2:0] rd,
                              logic [15:0] rsd, logic [15:0] rtd, logic [15:0] imm,
                              logic ur, logic src, logic [2:0] ctl, logic [4:0] ctl5);
    return '{1'b1, rs, rt, rd, rsd, rtd, imm, ur, src, ctl, ctl5};
  endfunction

  function automatic fwd_t fb(logic ew, logic [2:0] er, logic [15:0] ev,
                              logic ww, logic [2:0] wr, logic [15:0] wv);
    return '{ew, er, ev, ww, wr, wv};
  endfunction

  function automatic exp_t ex(logic [15:0] a, logic [15:0] b, logic [2:0] ctl,
                              logic [15:0] sd, logic [2:0] rd, logic [5:0] c6, logic lus);
    return '{a, b, ctl, sd, rd, c6, lus};
  endfunction

  task automatic add(logic rst, logic stl, logic fls, id_t id, fwd_t fw, exp_t e);
    row_t r;
    r.rst = rst; r.stl = stl; r.fls = fls; r.id = id; r.fw = fw; r.e = e;
    rows.push_back(r);
  endtask

  task automatic apply(logic rst, logic stl, logic fls, id_t id, fwd_t fw);
    reset = rst; stall = stl; flush = fls;
    id_valid = id.valid; id_rs = id.rs; id_rt = id.rt; id_rd = id.rd;
    id_rs_data = id.rs_data; id_rt_data = id.rt_data; id_imm = id.imm;
    id_uses_rt = id.uses_rt; id_alu_src = id.alu_src; id_alu_control = id.ctl;
    {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch} = id.ctl5;
    exm_reg_write = fw.exm_we; exm_rd = fw.exm_rd; exm_result = fw.exm_res;
    wb_reg_write = fw.wb_we; wb_rd = fw.wb_rd; wb_result = fw.wb_res;
  endtask

  task automatic check(string name, exp_t e);
    exp_t act;
    act = {alu_a, alu_b, alu_control, ex_store_data, ex_rd, ex_valid, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, load_use_stall};
    vectors++;
    if (act !== e) begin
      miscompares++;
      $display("FAIL %s: got a=%h b=%h ctl=%b sd=%h rd=%0d c6=%b lus=%b, expected a=%h b=%h ctl=%b sd=%h rd=%0d c6=%b lus=%b",
               name, act.a, act.b, act.ctl, act.sd, act.rd, act.c6, act.lus,
               e.a, e.b, e.ctl, e.sd, e.rd, e.c6, e.lus);
    end
  endtask

  // Reference: newest writer of a nonzero register wins, else the latched read value.
  function automatic logic [15:0] ref_fwd(logic [2:0] src, logic [15:0] held, fwd_t f);
    logic        we[2];
    logic [2:0]  rd[2];
    logic [15:0] val[2];
    we[0] = f.exm_we; rd[0] = f.exm_rd; val[0] = f.exm_res;
    we[1] = f.wb_we;  rd[1] = f.wb_rd;  val[1] = f.wb_res;
    if (src == 3'd0) return held;
    for (int k = 0; k < 2; k++) if (we[k] && rd[k] == src) return val[k];
    return held;
  endfunction

  function automatic logic ref_hazard(id_t s, id_t d);
    logic load_in_ex;
    load_in_ex = s.valid && s.ctl5[3] && (s.rd != 3'd0);
    return load_in_ex && d.valid && ((d.rs == s.rd) || (d.uses_rt && d.rt == s.rd));
  endfunction

  function automatic exp_t ref_out(id_t s, fwd_t f, id_t d);
    logic [15:0] rtv;
    rtv = ref_fwd(s.rt, s.rt_data, f);
    return ex(ref_fwd(s.rs, s.rs_data, f), s.alu_src ? s.imm : rtv, s.ctl, rtv, s.rd,
              {s.valid, s.ctl5}, ref_hazard(s, d));
  endfunction

  function automatic id_t rand_id();
    id_t r;
    r.valid   = ($urandom_range(0, 4) != 0);
    r.rs      = 3'($urandom_range(0, 3));
    r.rt      = 3'($urandom_range(0, 3));
    r.rd      = 3'($urandom_range(0, 3));
    r.rs_data = 16'($urandom);
    r.rt_data = 16'($urandom);
    r.imm     = 16'($urandom);
    r.uses_rt = 1'($urandom);
    r.alu_src = 1'($urandom);
    r.ctl     = 3'($urandom_range(0, 4));
    r.ctl5    = 5'($urandom);
    r.ctl5[3] = ($urandom_range(0, 2) == 0);
    return r;
  endfunction

  initial begin
    id_t  nop, nof_id, add0, fw2, r0i, sw, lw, dep, nodep, m, d;
    fwd_t nof, f;
    exp_t zero, e77, elw;
    logic rst, stl, fls;

    nop = '0; nof = '0; zero = '0; nof_id = '0;
    apply(1'b1, 1'b0, 1'b0, nop, nof);

    add0  = ins(3'd1, 3'd2, 3'd3, 16'h0005, 16'h0007, 16'h0000, 1'b1, 1'b0, 3'b000, 5'b10000);
    fw2   = ins(3'd2, 3'd0, 3'd1, 16'h0042, 16'h0003, 16'h0000, 1'b1, 1'b0, 3'b011, 5'b10000);
    r0i   = ins(3'd0, 3'd5, 3'd6, 16'h0077, 16'h0008, 16'h0000, 1'b1, 1'b0, 3'b010, 5'b10000);
    sw    = ins(3'd1, 3'd4, 3'd0, 16'h0100, 16'h0009, 16'hFFFC, 1'b1, 1'b1, 3'b000, 5'b00100);
    lw    = ins(3'd1, 3'd3, 3'd3, 16'h0010, 16'h0000, 16'h0004, 1'b0, 1'b1, 3'b000, 5'b11010);
    dep   = ins(3'd3, 3'd1, 3'd4, 16'h0005, 16'h0020, 16'h0000, 1'b1, 1'b0, 3'b000, 5'b10000);
    nodep = ins(3'd1, 3'd3, 3'd2, 16'h0001, 16'h0000, 16'h0007, 1'b0, 1'b1, 3'b001, 5'b10000);
    e77   = ex(16'h0077, 16'h0008, 3'b010, 16'h0008, 3'd6, 6'b110000, 1'b0);
    elw   = ex(16'h0010, 16'h0004, 3'b000, 16'h0000, 3'd3, 6'b111010, 1'b0);

    add(1'b1, 1'b0, 1'b0, ins(3'd3, 3'd4, 3'd5, 16'h1234, 16'h5678, 16'h0009, 1'b1, 1'b0, 3'b001, 5'b11111),
        fb(1'b1, 3'd3, 16'hAAAA, 1'b1, 3'd4, 16'hBBBB), zero);
    add(1'b0, 1'b0, 1'b0, add0, nof, zero);
    add(1'b0, 1'b0, 1'b0, nop, nof, ex(16'h0005, 16'h0007, 3'b000, 16'h0007, 3'd3, 6'b110000, 1'b0));
    add(1'b0, 1'b0, 1'b0, fw2, nof, zero);
    add(1'b0, 1'b1, 1'b0, nop, fb(1'b1, 3'd2, 16'h1111, 1'b1, 3'd2, 16'h2222),
        ex(16'h1111, 16'h0003, 3'b011, 16'h0003, 3'd1, 6'b110000, 1'b0));
    add(1'b0, 1'b1, 1'b0, nop, fb(1'b0, 3'd2, 16'h1111, 1'b1, 3'd2, 16'h2222),
        ex(16'h2222, 16'h0003, 3'b011, 16'h0003, 3'd1, 6'b110000, 1'b0));
    add(1'b0, 1'b0, 1'b0, r0i, fb(1'b1, 3'd0, 16'h1111, 1'b1, 3'd0, 16'h2222),
        ex(16'h0042, 16'h0003, 3'b011, 16'h0003, 3'd1, 6'b110000, 1'b0));
    add(1'b0, 1'b1, 1'b0, nop, fb(1'b1, 3'd0, 16'h1111, 1'b1, 3'd0, 16'h2222), e77);
    add(1'b0, 1'b1, 1'b0, nop, fb(1'b1, 3'd5, 16'h3333, 1'b0, 3'd0, 16'h0000),
        ex(16'h0077, 16'h3333, 3'b010, 16'h3333, 3'd6, 6'b110000, 1'b0));
    add(1'b0, 1'b1, 1'b0, nop, nof, e77);
    add(1'b0, 1'b0, 1'b0, sw, nof, e77);
    add(1'b0, 1'b0, 1'b0, nop, fb(1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 16'hBEEF),
        ex(16'h0100, 16'hFFFC, 3'b000, 16'hBEEF, 3'd0, 6'b100100, 1'b0));
    add(1'b0, 1'b0, 1'b0, lw, nof, zero);
    add(1'b0, 1'b0, 1'b0, dep, nof, ex(16'h0010, 16'h0004, 3'b000, 16'h0000, 3'd3, 6'b111010, 1'b1));
    add(1'b0, 1'b0, 1'b0, dep, fb(1'b1, 3'd3, 16'h0014, 1'b0, 3'd0, 16'h0000), zero);
    add(1'b0, 1'b0, 1'b0, nop, fb(1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 16'hCAFE),
        ex(16'hCAFE, 16'h0020, 3'b000, 16'h0020, 3'd4, 6'b110000, 1'b0));
    add(1'b0, 1'b0, 1'b0, lw, nof, zero);
    add(1'b0, 1'b0, 1'b0, nodep, nof, elw);
    add(1'b0, 1'b1, 1'b1, nop, nof, ex(16'h0001, 16'h0007, 3'b001, 16'h0000, 3'd2, 6'b110000, 1'b0));
    add(1'b0, 1'b0, 1'b1, nodep, nof, zero);
    add(1'b0, 1'b0, 1'b0, lw, nof, zero);
    add(1'b1, 1'b0, 1'b0, dep, nof, zero);
    add(1'b0, 1'b0, 1'b0, nop, nof, zero);

    foreach (rows[i]) begin
      @(negedge clk);
      apply(rows[i].rst, rows[i].stl, rows[i].fls, rows[i].id, rows[i].fw);
      #1;
      check($sformatf("dir%0d", i), rows[i].e);
    end

    // Randomized run; last directed row leaves the stage empty.
    m = nof_id;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 39) == 0);
      stl = ($urandom_range(0, 3) == 0);
      fls = ($urandom_range(0, 7) == 0);
      d   = rand_id();
      f.exm_we  = 1'($urandom); f.exm_rd = 3'($urandom_range(0, 3)); f.exm_res = 16'($urandom);
      f.wb_we   = 1'($urandom); f.wb_rd  = 3'($urandom_range(0, 3)); f.wb_res  = 16'($urandom);
      apply(rst, stl, fls, d, f);
      if (rst) m = nof_id;
      #1;
      check($sformatf("rnd%0d", n), ref_out(m, f, d));
      if (rst || fls) m = nof_id;
      else if (stl) m = m;
      else if (ref_hazard(m, d)) m = nof_id;
      else m = d;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
